fft_agu_cfg: RTL and testbench
==============================

Name: fft_agu_cfg

Overview:
Runtime-configurable radix-2 DIT address generation unit. It is the parametrised successor to the fixed-size AGU. It sequences all butterflies of an in-place ping-pong FFT of length 2^cfg_log2n, for any cfg_log2n up to N_LOG2_MAX. Additions over the fixed-size unit: backpressure from the BFU, forward/inverse mode, abort, and config error reporting. It drives the ping-pong RAM read ports, the shared twiddle ROM (sized for N_MAX) and the BFU input-valid.

Parameters:
N_LOG2_MAX, 10, log2 of largest supported FFT size; twiddle ROM holds N_MAX/2 entries
FLUSH_CYCLES, BFU_LAT, cycles of BFU+RAM pipeline drain between stages; must be >=1
LOG2_W, $clog2(N_LOG2_MAX+1), width of cfg_log2n and stage

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  level request; accepted only in IDLE
abort  in  1  synchronous abort, any state
cfg_log2n  in  LOG2_W  FFT size (log2); sampled when start is accepted
cfg_inverse  in  1  1 = IFFT; sampled when start is accepted
in_ready  in  1  BFU can accept a butterfly this cycle
in_valid  out  1  butterfly issue valid
rd_addr_a  out  N_LOG2_MAX  top-leg address
rd_addr_b  out  N_LOG2_MAX  bottom-leg address
twiddle_idx  out  N_LOG2_MAX-1  index into the N_MAX-sized twiddle ROM
tw_conj  out  1  conjugate twiddle (latched inverse flag)
stage  out  LOG2_W  current stage, 0..L-1
bank_sel  out  1  0: read ram0 / write ram1; 1: the reverse
result_bank  out  1  bank holding the final result; valid while done=1
busy  out  1  RUN or FLUSH
done  out  1  high in DONE
cfg_err  out  1  one-cycle pulse when start carries an illegal cfg_log2n

Behaviour:
- Reset (rst=1 at a clk edge) forces IDLE and sets every output and counter to 0. This has priority over everything, including mid-RUN or mid-FLUSH.
- States: IDLE, RUN, FLUSH, DONE.
- Let L = latched cfg_log2n, N = 2^L, s = stage, stride = 2^s, and j, g = butterfly index within group and group index.
- IDLE, start=1, cfg_log2n in 1..N_LOG2_MAX:
  - Latch L and cfg_inverse.
  - Clear s, j, g and bank_sel.
  - Next state RUN.
- IDLE, start=1, cfg_log2n illegal (0 or >N_LOG2_MAX): cfg_err=1 for exactly one cycle; stay in IDLE. While start stays high with the same illegal value, cfg_err pulses every cycle.
- RUN:
  - in_valid=1.
  - rd_addr_a = (g << (s+1)) + j; rd_addr_b = rd_addr_a + stride. Addresses are zero-extended and never reach N.
  - twiddle_idx = j * (N_MAX >> (s+1)), truncated to N_LOG2_MAX-1 bits. This is independent of L, so one ROM serves every size.
  - Counters advance only on a handshake (in_valid && in_ready). If in_ready=0, all outputs hold stable.
  - Stepping: j increments; when j == stride-1, j goes to 0 and g increments. The last butterfly is j == stride-1 and g == N/2^(s+1) - 1.
- Handshake on the last butterfly of the stage: load the flush counter with FLUSH_CYCLES-1; next state FLUSH.
- FLUSH:
  - in_valid=0, busy=1; lasts exactly FLUSH_CYCLES cycles.
  - On the final cycle, if s == L-1: next state DONE.
  - Otherwise: s increments, j and g clear, bank_sel toggles, next state RUN.
- Throughput: with no stalls, one run takes L*(N/2 + FLUSH_CYCLES) cycles from the first RUN cycle to the first DONE cycle.
- DONE:
  - done=1, busy=0.
  - result_bank = ~bank_sel, the bank written by the last stage.
  - stage and bank_sel hold.
  - If start=0, next state IDLE. A start held high never restarts a run.
- tw_conj equals the latched inverse flag during RUN and FLUSH, and 0 otherwise. The BFU applies 1/N scaling, not this unit.
- abort=1 in RUN, FLUSH or DONE: next state IDLE and outputs deasserted the following cycle; done is never asserted. In IDLE, abort=1 blocks start acceptance that cycle. Reset takes priority over abort.
- L=1 is a single stage with one butterfly (0,1) and twiddle_idx 0.

Decomposition:
- Add to the package fft_consts: N_LOG2_MAX, BFU_LAT, and the typedef agu_state_e {IDLE, RUN, FLUSH, DONE}.
- One sub-module, agu_bfly_counter. It holds the j/g counters, the last-butterfly detect and the address/twiddle arithmetic. Inputs: s, L, advance, clear. Outputs: addresses, twiddle_idx, last.
- The top level keeps the FSM, flush counter, bank_sel and config latch.

Test Plan:
(All scenarios use N_LOG2_MAX=4 and FLUSH_CYCLES=2 unless noted.)
1. Normal run, in_ready=1, cfg_log2n=3:
   - stage 0 issues (0,1),(2,3),(4,5),(6,7), all twiddle 0.
   - stage 1 issues (0,2)/0, (1,3)/4, (4,6)/0, (5,7)/4.
   - stage 2 issues (0,4)/0, (1,5)/2, (2,6)/4, (3,7)/6.
   - done arrives 18 cycles after the first RUN cycle; result_bank=1.
2. cfg_log2n=4, cfg_inverse=1: 4 stages of 8 butterflies each; tw_conj=1 throughout; result_bank=0; total 40 cycles.
3. Random in_ready stalls, cfg_log2n=3: address/twiddle sequence identical to scenario 1; outputs hold stable during every stall cycle; no butterfly dropped or duplicated.
4. Illegal config: start with cfg_log2n=0, then 5 → one cfg_err pulse per attempt, busy stays 0; next start with 2 → normal 2-stage run.
5. Interruptions:
   - abort asserted in stage 1 FLUSH → IDLE next cycle, done never asserted; an immediate restart produces the full scenario 1 sequence.
   - rst mid-RUN → all outputs 0 the next cycle.
6. cfg_log2n=1 → one butterfly (0,1), twiddle 0, then FLUSH of 2 cycles, then DONE. start held high in DONE → stays in DONE; start drops → IDLE.

Source files
------------

// File: rtl/fft_agu_cfg_pkg.sv
// fft_consts: shared constants and types for the runtime-configurable
// radix-2 DIT address generation unit (fft_agu_cfg) and its sub-module.
//   N_LOG2_MAX : log2 of the largest supported FFT size (twiddle ROM = N_MAX/2)
//   BFU_LAT    : butterfly unit + RAM write-back latency, used as the default
//                inter-stage flush length
//   agu_state_e: sequencer states
package fft_consts;

  localparam int N_LOG2_MAX = 10;
  localparam int BFU_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } agu_state_e;

endpackage

// File: rtl/fft_agu_cfg_bfly.sv
// agu_bfly_counter: butterfly index counters (j within group, g group index)
// for one stage of a radix-2 DIT FFT, plus the address/twiddle arithmetic.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   s_i, l_i      : current stage and latched log2 FFT size
//   advance_i     : step to the next butterfly (issue handshake)
//   clear_i       : restart at butterfly 0 (new run / new stage / abort)
//   addr_a_o/b_o  : top/bottom leg RAM addresses
//   twiddle_idx_o : index into the N_MAX-sized twiddle ROM
//   last_o        : current butterfly is the last one of the stage
module agu_bfly_counter
  import fft_consts::*;
#(
  parameter int N_LOG2_MAX = fft_consts::N_LOG2_MAX,
  parameter int LOG2_W     = $clog2(N_LOG2_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOG2_W-1:0]       s_i,
  input  logic [LOG2_W-1:0]       l_i,
  input  logic                    advance_i,
  input  logic                    clear_i,
  output logic [N_LOG2_MAX-1:0]   addr_a_o,
  output logic [N_LOG2_MAX-1:0]   addr_b_o,
  output logic [N_LOG2_MAX-2:0]   twiddle_idx_o,
  output logic                    last_o
);

  localparam int NL = N_LOG2_MAX;

  logic [NL-1:0] j_q, j_d;
  logic [NL-1:0] g_q, g_d;
  logic [NL-1:0] stride;
  logic [NL-1:0] g_last;
  logic          j_last;

  assign stride = NL'(1) << s_i;
  // Groups per stage is N / 2^(s+1) = 2^(L-1-s).
  assign g_last = (NL'(1) << (l_i - s_i - LOG2_W'(1))) - NL'(1);
  assign j_last = (j_q == stride - NL'(1));
  assign last_o = j_last && (g_q == g_last);

  assign addr_a_o = (g_q << (s_i + LOG2_W'(1))) + j_q;
  assign addr_b_o = addr_a_o + stride;
  // j * (N_MAX >> (s+1)) is a left shift; j < 2^s keeps it below N_MAX/2,
  // and it does not depend on L, so one ROM serves every size.
  assign twiddle_idx_o = (NL-1)'(j_q) << (LOG2_W'(NL - 1) - s_i);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    j_d = j_q;
    g_d = g_q;
    if (clear_i) begin
      j_d = '0;
      g_d = '0;
    end else if (advance_i) begin
      if (j_last) begin
        j_d = '0;
        g_d = last_o ? '0 : g_q + NL'(1);
      end else begin
        j_d = j_q + NL'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q <= '0;
      g_q <= '0;
    end else begin
      j_q <= j_d;
      g_q <= g_d;
    end
  end

endmodule

// File: rtl/fft_agu_cfg.sv
// fft_agu_cfg: runtime-configurable radix-2 DIT address generation unit for
// an in-place ping-pong FFT of length 2^cfg_log2n (1 <= cfg_log2n <= N_LOG2_MAX).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, abort           : run request (IDLE only) / abort from any state
//   cfg_log2n, cfg_inverse : size and direction, latched when start is taken
//   in_ready / in_valid    : butterfly issue handshake with the BFU
//   rd_addr_a, rd_addr_b   : RAM read addresses of the two butterfly legs
//   twiddle_idx, tw_conj   : twiddle ROM index and conjugate (inverse) flag
//   stage, bank_sel        : current stage and ping-pong read bank
//   result_bank            : bank holding the result while done=1
//   busy, done, cfg_err    : status; cfg_err pulses on an illegal size request
module fft_agu_cfg
  import fft_consts::*;
#(
  parameter int N_LOG2_MAX   = fft_consts::N_LOG2_MAX,
  parameter int FLUSH_CYCLES = fft_consts::BFU_LAT,
  parameter int LOG2_W       = $clog2(N_LOG2_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LOG2_W-1:0]       cfg_log2n,
  input  logic                    cfg_inverse,
  input  logic                    in_ready,
  output logic                    in_valid,
  output logic [N_LOG2_MAX-1:0]   rd_addr_a,
  output logic [N_LOG2_MAX-1:0]   rd_addr_b,
  output logic [N_LOG2_MAX-2:0]   twiddle_idx,
  output logic                    tw_conj,
  output logic [LOG2_W-1:0]       stage,
  output logic                    bank_sel,
  output logic                    result_bank,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  agu_state_e        state_q, state_d;
  logic [LOG2_W-1:0] l_q, l_d;
  logic [LOG2_W-1:0] s_q, s_d;
  logic              inv_q, inv_d;
  logic              bank_q, bank_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic              cfg_err_q, cfg_err_d;

  logic                  cnt_clear;
  logic                  cnt_advance;
  logic                  cnt_last;
  logic                  cfg_legal;
  logic [N_LOG2_MAX-1:0] addr_a, addr_b;
  logic [N_LOG2_MAX-2:0] tw_idx;

  assign cfg_legal   = (cfg_log2n != '0) && (cfg_log2n <= LOG2_W'(N_LOG2_MAX));
  assign cnt_advance = (state_q == RUN) && in_ready;

  agu_bfly_counter #(
    .N_LOG2_MAX (N_LOG2_MAX),
    .LOG2_W     (LOG2_W)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .s_i           (s_q),
    .l_i           (l_q),
    .advance_i     (cnt_advance),
    .clear_i       (cnt_clear),
    .addr_a_o      (addr_a),
    .addr_b_o      (addr_b),
    .twiddle_idx_o (tw_idx),
    .last_o        (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    s_d       = s_q;
    inv_d     = inv_q;
    bank_d    = bank_q;
    fcnt_d    = fcnt_q;
    cfg_err_d = 1'b0;
    cnt_clear = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      s_d       = '0;
      bank_d    = 1'b0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // abort in IDLE only blocks acceptance of start this cycle.
          if (start && !abort) begin
            if (cfg_legal) begin
              l_d       = cfg_log2n;
              inv_d     = cfg_inverse;
              s_d       = '0;
              bank_d    = 1'b0;
              cnt_clear = 1'b1;
              state_d   = RUN;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (in_ready && cnt_last) begin
            fcnt_d  = FCW'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) begin
            if (s_q == l_q - LOG2_W'(1)) begin
              state_d = DONE;
            end else begin
              s_d       = s_q + LOG2_W'(1);
              bank_d    = ~bank_q;
              cnt_clear = 1'b1;
              state_d   = RUN;
            end
          end else begin
            fcnt_d = fcnt_q - FCW'(1);
          end
        end
        DONE: begin
          // A start held high from the previous run must not restart it.
          if (!start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      l_q       <= '0;
      s_q       <= '0;
      inv_q     <= 1'b0;
      bank_q    <= 1'b0;
      fcnt_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      s_q       <= s_d;
      inv_q     <= inv_d;
      bank_q    <= bank_d;
      fcnt_q    <= fcnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Address and twiddle outputs are forced to 0 outside RUN so the read ports
  // and ROM see a quiet bus while nothing is issued.
  assign in_valid    = (state_q == RUN);
  assign rd_addr_a   = in_valid ? addr_a : '0;
  assign rd_addr_b   = in_valid ? addr_b : '0;
  assign twiddle_idx = in_valid ? tw_idx : '0;
  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign tw_conj     = busy && inv_q;
  assign done        = (state_q == DONE);
  assign result_bank = done && !bank_q;
  assign stage       = s_q;
  assign bank_sel    = bank_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_fft_agu_cfg.sv
module tb_fft_agu_cfg;

  localparam int NL  = 4;
  localparam int FC  = 2;
  localparam int LW  = $clog2(NL + 1);
  localparam int NMAX = 1 << NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [LW-1:0] cfg_log2n;
  logic          cfg_inverse;
  logic          in_ready;
  logic          in_valid;
  logic [NL-1:0] rd_addr_a;
  logic [NL-1:0] rd_addr_b;
  logic [NL-2:0] twiddle_idx;
  logic          tw_conj;
  logic [LW-1:0] stage;
  logic          bank_sel;
  logic          result_bank;
  logic          busy;
  logic          done;
  logic          cfg_err;

  fft_agu_cfg #(
    .N_LOG2_MAX   (NL),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_log2n   (cfg_log2n),
    .cfg_inverse (cfg_inverse),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .twiddle_idx (twiddle_idx),
    .tw_conj     (tw_conj),
    .stage       (stage),
    .bank_sel    (bank_sel),
    .result_bank (result_bank),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the full butterfly list of an FFT of size 2^l, from the
  // DIT loop nest stage -> group -> index within group.
  typedef struct {
    int a;
    int b;
    int tw;
    int s;
  } bfly_t;

  bfly_t exp_q[$];

  function automatic logic [31:0] pack(int a, int b, int tw, int s, int bank, int conj);
    return 32'((a << 12) | (b << 8) | (tw << 5) | (s << 2) | (bank << 1) | conj);
  endfunction

  function automatic logic [31:0] obs_pack();
    return pack(int'(rd_addr_a), int'(rd_addr_b), int'(twiddle_idx),
                int'(stage), int'(bank_sel), int'(tw_conj));
  endfunction

  function automatic logic [31:0] all_outputs();
    return 32'({in_valid, rd_addr_a, rd_addr_b, twiddle_idx, tw_conj, stage,
                bank_sel, result_bank, busy, done, cfg_err});
  endfunction

  task automatic build_model(input int l);
    exp_q.delete();
    for (int s = 0; s < l; s++) begin
      int span = 1 << (s + 1);
      for (int g = 0; g < (1 << l) / span; g++) begin
        for (int j = 0; j < (1 << s); j++) begin
          bfly_t e;
          e.a  = g * span + j;
          e.b  = e.a + (1 << s);
          e.tw = j * (NMAX / span);
          e.s  = s;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_run(input int l, input bit inv, input int stall_pct, input bit hold_start);
    int          cyc = 0;
    int          issued = 0;
    int          total;
    int          busy_bad = 0;
    bit          got_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev = '0;
    logic [31:0] obs;

    build_model(l);
    total = exp_q.size();
    start       = 1'b1;
    cfg_log2n   = LW'(l);
    cfg_inverse = inv;
    in_ready    = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;

    while (cyc < 3000 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy) busy_bad++;
        if (in_valid) begin
          obs = obs_pack();
          if (prev_stall) check("stall_hold", obs, prev);
          in_ready = ($urandom_range(99) >= stall_pct);
          if (exp_q.size() != 0) begin
            bfly_t e = exp_q[0];
            check("bfly", obs, pack(e.a, e.b, e.tw, e.s, e.s & 1, int'(inv)));
            if (in_ready) void'(exp_q.pop_front());
          end
          if (in_ready) issued++;
          prev_stall = !in_ready;
          prev = obs;
        end else begin
          in_ready   = 1'($urandom_range(1));
          prev_stall = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end

    check("done_seen", 32'(got_done), 1);
    check("bfly_count", issued, total);
    check("busy_in_run", busy_bad, 0);
    if (got_done) begin
      if (stall_pct == 0) check("latency", cyc, l * ((1 << l) / 2 + FC));
      check("result_bank", 32'(result_bank), l & 1);
      check("done_status", {busy, in_valid, tw_conj}, 0);
      if (hold_start) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("done_hold", 32'(done), 1);
        end
        start = 1'b0;
      end
      @(negedge clk);
      check("idle_after_done", {done, busy}, 0);
    end else begin
      start = 1'b0;
      pulse_reset();
    end
    in_ready = 1'b1;
  endtask

  task automatic illegal_try(input int l, input int hold_cycles);
    int errs = 0;
    int busy_seen = 0;
    start     = 1'b1;
    cfg_log2n = LW'(l);
    for (int k = 0; k < hold_cycles + 3; k++) begin
      @(negedge clk);
      if (k == hold_cycles - 1) start = 1'b0;
      errs      += int'(cfg_err);
      busy_seen += int'(busy);
    end
    check($sformatf("cfg_err_pulses_%0d", l), errs, hold_cycles);
    check($sformatf("cfg_err_busy_%0d", l), busy_seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  reached;
    int  done_cnt;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_log2n   = '0;
    cfg_inverse = 1'b0;
    in_ready    = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 0);

    // Normal runs without stalls.
    do_run(3, 1'b0, 0, 1'b0);
    do_run(4, 1'b1, 0, 1'b0);

    // Stalled runs: same sequence, outputs stable across stalls.
    do_run(3, 1'b0, 40, 1'b0);
    for (int r = 0; r < 4; r++)
      do_run(int'($urandom_range(NL, 1)), 1'($urandom_range(1)), 30, 1'b0);

    // Illegal configurations, then a legal one.
    illegal_try(0, 1);
    illegal_try(5, 1);
    illegal_try(7, 3);
    do_run(2, 1'b0, 0, 1'b0);

    // Abort during stage 1 flush.
    start     = 1'b1;
    cfg_log2n = LW'(3);
    cfg_inverse = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 0;
    for (int k = 0; k < 200 && reached == 0; k++) begin
      if (busy && !in_valid && stage == LW'(1)) reached = 1;
      else @(negedge clk);
    end
    check("abort_reach_flush", reached, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", all_outputs(), 0);
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      done_cnt += int'(done) + int'(busy);
    end
    check("abort_no_done", done_cnt, 0);
    do_run(3, 1'b0, 0, 1'b0);

    // Abort in IDLE blocks start for that cycle.
    start = 1'b1;
    abort = 1'b1;
    cfg_log2n = LW'(2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_blocks_start", 32'(busy), 0);

    // Reset mid-run.
    start       = 1'b1;
    cfg_log2n   = LW'(4);
    cfg_inverse = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_run", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stays_idle", all_outputs(), 0);

    // Smallest size, start held high through DONE.
    do_run(1, 1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
